// File: rtl/serial_config_controller.sv
// Serial configuration link receiver: synchronizes sclk/cs_n/sdata into clk,
// shifts one LSB-first address+data frame and issues a single-cycle register write.
module serial_config_controller #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  sdata,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  frame_err,
    output logic [7:0]            err_count
);

    localparam int W  = ADDR_WIDTH + DATA_WIDTH;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2,
        TAIL   = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0]  cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0]  sdata_sync_q, sdata_sync_d;
    logic [SYNC_STAGES-1:0]  fill_q, fill_d;
    logic                    sclk_prev_q, sclk_prev_d;
    logic                    armed_q, armed_d;
    logic                    overrun_q, overrun_d;
    logic [CW-1:0]           bit_cnt_q, bit_cnt_d;
    logic [W-1:0]            shreg_q, shreg_d;
    logic                    wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic                    frame_err_q, frame_err_d;
    logic [7:0]              err_count_q, err_count_d;

    logic sclk_s, cs_s, sdata_s, sclk_rise, sync_live;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sdata_s   = sdata_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    // The synchronizers hold reset values (cs_n high) until real samples reach the
    // last stage; arming on those would start a frame in the middle of a live one.
    assign sync_live = fill_q[SYNC_STAGES-1];

    always_comb begin
        sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        cs_sync_d    = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
        sdata_sync_d = {sdata_sync_q[SYNC_STAGES-2:0], sdata};
        fill_d       = {fill_q[SYNC_STAGES-2:0], 1'b1};
        sclk_prev_d  = sclk_s;
    end

    always_comb begin
        state_d     = state_q;
        armed_d     = armed_q;
        overrun_d   = overrun_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_err_d = 1'b0;
        err_count_d = err_count_q;

        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                shreg_d   = '0;
                overrun_d = 1'b0;
                if (cs_s && sync_live) begin
                    armed_d = 1'b1;
                end
                if (armed_q && !cs_s) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_s) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                end else if (sclk_rise) begin
                    shreg_d   = {sdata_s, shreg_q[W-1:1]};
                    bit_cnt_d = bit_cnt_q + CW'(1);
                    if (bit_cnt_q == CW'(W - 1)) begin
                        state_d   = COMMIT;
                        wr_en_d   = 1'b1;
                        wr_addr_d = shreg_d[ADDR_WIDTH-1:0];
                        wr_data_d = shreg_d[W-1:ADDR_WIDTH];
                    end
                end
            end
            COMMIT: begin
                state_d = TAIL;
            end
            TAIL: begin
                if (sclk_rise) begin
                    overrun_d = 1'b1;
                end
                if (cs_s) begin
                    state_d     = IDLE;
                    frame_err_d = overrun_q;
                    overrun_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (frame_err_d && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            sclk_sync_q  <= '0;
            cs_sync_q    <= '1;
            sdata_sync_q <= '0;
            fill_q       <= '0;
            sclk_prev_q  <= 1'b0;
            armed_q      <= 1'b0;
            overrun_q    <= 1'b0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_err_q  <= 1'b0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            sclk_sync_q  <= sclk_sync_d;
            cs_sync_q    <= cs_sync_d;
            sdata_sync_q <= sdata_sync_d;
            fill_q       <= fill_d;
            sclk_prev_q  <= sclk_prev_d;
            armed_q      <= armed_d;
            overrun_q    <= overrun_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_err_q  <= frame_err_d;
            err_count_q  <= err_count_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = (state_q != IDLE);
    assign frame_err = frame_err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_serial_config_controller.sv
// Directed bench for serial_config_controller: frames are driven bit by bit on the
// raw pins and every register write is matched against an expected queue.
module tb_serial_config_controller;

    logic        clk;
    logic        reset;
    logic        sclk;
    logic        cs_n;
    logic        sdata;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        frame_err;
    logic [7:0]  err_count;

    int n_checks = 0;
    int n_err    = 0;
    int wr_cnt   = 0;
    int err_hi   = 0;

    logic [39:0] exp_q[$];

    serial_config_controller #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (32),
        .SYNC_STAGES(2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sclk     (sclk),
        .cs_n     (cs_n),
        .sdata    (sdata),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .frame_err(frame_err),
        .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: each write strobe consumes one expected {addr,data}; frame_err
    // high cycles are counted so a stretched pulse shows up as an extra count.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 64'd1, 64'd0);
            end else begin
                check("wr_frame", {24'd0, wr_addr, wr_data}, {24'd0, exp_q.pop_front()});
            end
        end
        if (frame_err === 1'b1) begin
            err_hi++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        sdata = b;
        tick(1);
        sclk = 1'b1;
        tick(4);
        sclk = 1'b0;
        tick(4);
    endtask

    task automatic send_frame(input logic [39:0] f, input int nbits, input int gap);
        cs_n = 1'b0;
        tick(4);
        check("busy_in_frame", {63'd0, busy}, 64'd1);
        for (int i = 0; i < nbits; i++) begin
            send_bit(i < 40 ? f[i] : 1'b0);
        end
        cs_n = 1'b1;
        tick(gap);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        tick(cycles);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        sclk  = 1'b0;
        cs_n  = 1'b1;
        sdata = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(1);
        check("rst_wr_en", {63'd0, wr_en}, 64'd0);
        check("rst_wr_addr", {56'd0, wr_addr}, 64'd0);
        check("rst_wr_data", {32'd0, wr_data}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_frame_err", {63'd0, frame_err}, 64'd0);
        check("rst_err_count", {56'd0, err_count}, 64'd0);
        tick(5);

        // Nominal frame.
        exp_q.push_back({8'h05, 32'hDEADBEEF});
        send_frame({32'hDEADBEEF, 8'h05}, 40, 8);
        check("nom_wr_cnt", 64'(wr_cnt), 64'd1);
        check("nom_err_hi", 64'(err_hi), 64'd0);
        check("nom_err_count", {56'd0, err_count}, 64'd0);
        check("nom_busy", {63'd0, busy}, 64'd0);
        check("nom_wr_addr_hold", {56'd0, wr_addr}, 64'h05);

        // Short frame: 39 bits.
        send_frame({32'hFFFF0000, 8'hAA}, 39, 8);
        check("short_wr_cnt", 64'(wr_cnt), 64'd1);
        check("short_err_hi", 64'(err_hi), 64'd1);
        check("short_err_count", {56'd0, err_count}, 64'd1);
        check("short_busy", {63'd0, busy}, 64'd0);

        // Overrun: 41 bits, write issued after bit 40, error at cs_n rise.
        exp_q.push_back({8'h7F, 32'h12345678});
        send_frame({32'h12345678, 8'h7F}, 41, 8);
        check("ovr_wr_cnt", 64'(wr_cnt), 64'd2);
        check("ovr_err_hi", 64'(err_hi), 64'd2);
        check("ovr_err_count", {56'd0, err_count}, 64'd2);
        check("ovr_busy", {63'd0, busy}, 64'd0);

        // Reset mid-frame with cs_n held low: the rest of the frame is ignored.
        cs_n = 1'b0;
        tick(4);
        for (int i = 0; i < 20; i++) send_bit(i[0]);
        do_reset(1);
        tick(4);
        check("rmf_busy_after_rst", {63'd0, busy}, 64'd0);
        check("rmf_err_count_rst", {56'd0, err_count}, 64'd0);
        for (int i = 0; i < 20; i++) send_bit(~i[0]);
        check("rmf_busy_tail", {63'd0, busy}, 64'd0);
        cs_n = 1'b1;
        tick(8);
        check("rmf_wr_cnt", 64'(wr_cnt), 64'd2);
        check("rmf_err_hi", 64'(err_hi), 64'd2);
        check("rmf_err_count", {56'd0, err_count}, 64'd0);
        exp_q.push_back({8'h01, 32'h00000001});
        send_frame({32'h00000001, 8'h01}, 40, 8);
        check("rmf_next_wr_cnt", 64'(wr_cnt), 64'd3);

        // Back-to-back frames, cs_n high for only 3 clk cycles between them.
        exp_q.push_back({8'hA5, 32'h0F0F1234});
        exp_q.push_back({8'h3C, 32'hCAFEF00D});
        send_frame({32'h0F0F1234, 8'hA5}, 40, 3);
        send_frame({32'hCAFEF00D, 8'h3C}, 40, 8);
        check("b2b_wr_cnt", 64'(wr_cnt), 64'd5);
        check("b2b_data_hold", {32'd0, wr_data}, 64'hCAFEF00D);
        check("b2b_err_count", {56'd0, err_count}, 64'd0);

        // sclk edge and cs_n rise land in the same synchronized cycle at bit 11.
        cs_n = 1'b0;
        tick(4);
        for (int i = 0; i < 10; i++) send_bit(1'b1);
        sdata = 1'b1;
        tick(1);
        sclk = 1'b1;
        cs_n = 1'b1;
        tick(4);
        sclk = 1'b0;
        tick(6);
        check("same_err_hi", 64'(err_hi), 64'd3);
        check("same_err_count", {56'd0, err_count}, 64'd1);
        check("same_wr_cnt", 64'(wr_cnt), 64'd5);
        check("same_busy", {63'd0, busy}, 64'd0);

        // Saturation: 256 short frames from a cleared counter.
        do_reset(2);
        tick(6);
        check("sat_start", {56'd0, err_count}, 64'd0);
        for (int k = 0; k < 256; k++) begin
            cs_n = 1'b0;
            tick(4);
            send_bit(1'b1);
            send_bit(1'b0);
            cs_n = 1'b1;
            tick(6);
            if (k == 253) check("sat_254", {56'd0, err_count}, 64'd254);
            if (k == 254) check("sat_255", {56'd0, err_count}, 64'd255);
        end
        check("sat_hold", {56'd0, err_count}, 64'd255);
        check("sat_err_hi", 64'(err_hi), 64'd259);
        check("sat_wr_cnt", 64'(wr_cnt), 64'd5);
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
